// File: rtl/magnitude_arb_pkg.sv
// Shared types and helpers for the magnitude arbiter: tag sizing, tag type
// and the tag-to-one-hot decode used for grants and returned results.
package magnitude_arb_pkg;

  localparam int DATA_W        = 16;
  localparam int NCH_DEFAULT   = 4;
  localparam int DEPTH_DEFAULT = 32;
  localparam int MAX_NCH       = 8;
  localparam int MAX_TAG_W     = 3;

  // Widest tag any legal channel count can need; narrower tags are cast into it.
  typedef logic [MAX_TAG_W-1:0] tag_t;

  function automatic int tag_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic logic [MAX_NCH-1:0] tag_onehot(input tag_t tag);
    logic [MAX_NCH-1:0] oh;
    oh      = '0;
    oh[tag] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/magnitude_arbiter_tag_fifo.sv
// First-word-fall-through tag FIFO: remembers which channel owns each
// sample in flight through the magnitude unit, in issue order.
module tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/magnitude_arbiter.sv
// Round-robin sharing of one in-order I/Q magnitude unit between NCH
// channels; a tag FIFO routes each returning magnitude back to its channel.
module magnitude_arbiter
  import magnitude_arb_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic [NCH*16-1:0]   s_i,
  input  logic [NCH*16-1:0]   s_q,
  input  logic [NCH-1:0]      s_valid,
  output logic [NCH-1:0]      s_ready,
  output logic [15:0]         mag_i,
  output logic [15:0]         mag_q,
  output logic                mag_valid,
  input  logic [15:0]         mag_h,
  input  logic                mag_h_valid,
  output logic [15:0]         out_h,
  output logic [NCH-1:0]      out_valid,
  output logic                err_orphan
);

  localparam int TAG_W = tag_width(NCH);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0]         rr_ptr;
  logic [TAG_W-1:0]         cand;
  logic [TAG_W-1:0]         grant_tag;
  logic                     grant_any;
  logic [TAG_W-1:0]         ret_tag;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            inflight;
  logic signed [DATA_W-1:0] sel_i;
  logic signed [DATA_W-1:0] sel_q;

  logic signed [DATA_W-1:0] issue_i_p1;
  logic signed [DATA_W-1:0] issue_q_p1;
  logic                     issue_vld_p1;
  logic [DATA_W-1:0]        ret_h_p1;
  logic [NCH-1:0]           ret_vld_p1;

  // Grant decisions use the registered occupancy, so a pop in the same
  // cycle as a full FIFO costs one bubble rather than a combinational path.
  always_comb begin
    grant_any = 1'b0;
    grant_tag = '0;
    cand      = '0;
    if (!fifo_full) begin
      for (int i = 0; i < NCH; i++) begin
        cand = TAG_W'((int'(rr_ptr) + i) % NCH);
        if (!grant_any && s_valid[cand]) begin
          grant_any = 1'b1;
          grant_tag = cand;
        end
      end
    end
  end

  assign s_ready = grant_any ? NCH'(tag_onehot(tag_t'(grant_tag))) : '0;
  assign sel_i   = $signed(s_i[DATA_W*grant_tag +: DATA_W]);
  assign sel_q   = $signed(s_q[DATA_W*grant_tag +: DATA_W]);
  assign pop     = mag_h_valid & ~fifo_empty;

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (aclk),
    .rst       (reset),
    .push      (grant_any),
    .push_data (grant_tag),
    .pop       (pop),
    .pop_data  (ret_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (inflight)
  );

  // p1: issue register toward the unit, return register toward the channels.
  always_ff @(posedge aclk) begin
    if (reset) begin
      rr_ptr       <= '0;
      issue_i_p1   <= '0;
      issue_q_p1   <= '0;
      issue_vld_p1 <= 1'b0;
      ret_h_p1     <= '0;
      ret_vld_p1   <= '0;
      err_orphan   <= 1'b0;
    end else begin
      issue_vld_p1 <= grant_any;
      if (grant_any) begin
        issue_i_p1 <= sel_i;
        issue_q_p1 <= sel_q;
        rr_ptr     <= (grant_tag == TAG_W'(NCH - 1)) ? '0 : grant_tag + 1'b1;
      end
      ret_vld_p1 <= pop ? NCH'(tag_onehot(tag_t'(ret_tag))) : '0;
      if (pop) ret_h_p1 <= mag_h;
      if (mag_h_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  assign mag_i     = issue_i_p1;
  assign mag_q     = issue_q_p1;
  assign mag_valid = issue_vld_p1;
  assign out_h     = ret_h_p1;
  assign out_valid = ret_vld_p1;

endmodule

// File: tb/tb_magnitude_arbiter.sv
// Bench for magnitude_arbiter: a fixed-latency magnitude unit model, a
// queue-based reference of grants/tags checked every cycle, plus directed cases.
module tb_magnitude_arbiter;

  localparam int NCH   = 4;
  localparam int DEPTH = 32;

  logic          aclk = 1'b0;
  logic          reset;
  logic [63:0]   s_i;
  logic [63:0]   s_q;
  logic [3:0]    s_valid;
  logic [3:0]    s_ready;
  logic [15:0]   mag_i;
  logic [15:0]   mag_q;
  logic          mag_valid;
  logic [15:0]   mag_h;
  logic          mag_h_valid;
  logic [15:0]   out_h;
  logic [3:0]    out_valid;
  logic          err_orphan;

  always #5 aclk = ~aclk;

  magnitude_arbiter #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .s_i         (s_i),
    .s_q         (s_q),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .mag_i       (mag_i),
    .mag_q       (mag_q),
    .mag_valid   (mag_valid),
    .mag_h       (mag_h),
    .mag_h_valid (mag_h_valid),
    .out_h       (out_h),
    .out_valid   (out_valid),
    .err_orphan  (err_orphan)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Magnitude unit model: in-order, fixed latency, not affected by the arbiter reset.
  typedef struct {
    int h;
    int due;
  } unit_t;

  unit_t uq[$];
  int    cyc          = 0;
  int    unit_lat     = 4;
  bit    force_orphan = 1'b0;

  function automatic int isqrt(input longint v);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return int'(r);
  endfunction

  task automatic tick();
    unit_t  u;
    longint a;
    longint b;
    @(posedge aclk);
    #1;
    cyc++;
    if (mag_valid === 1'b1) begin
      a     = longint'($signed(mag_i));
      b     = longint'($signed(mag_q));
      u.h   = isqrt(a * a + b * b);
      u.due = cyc + unit_lat;
      uq.push_back(u);
    end
    mag_h_valid = 1'b0;
    if (force_orphan) begin
      mag_h_valid = 1'b1;
      mag_h       = 16'h0bad;
    end else if (uq.size() > 0 && uq[0].due <= cyc) begin
      mag_h_valid = 1'b1;
      mag_h       = 16'(uq[0].h);
      void'(uq.pop_front());
    end
  endtask

  // Reference: a list of owed channels, a round-robin start index and an error bit.
  int          m_rr;
  int          m_tags[$];
  bit          m_ok = 1'b0;
  logic        exp_mv;
  logic [15:0] exp_mi;
  logic [15:0] exp_mq;
  logic [15:0] exp_oh;
  logic [3:0]  exp_ov;
  logic        exp_err;
  int          grant_log[$];
  int          ret_log[$];

  always @(negedge aclk) begin
    logic [3:0] er;
    int         g;
    int         k;
    int         t;
    er = '0;
    g  = -1;
    if (m_tags.size() < DEPTH) begin
      for (int i = 0; i < NCH; i++) begin
        k = (m_rr + i) % NCH;
        if (g < 0 && s_valid[k]) g = k;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    if (m_ok) begin
      chk("s_ready", 64'(s_ready), 64'(er));
      chk("mag_valid", 64'(mag_valid), 64'(exp_mv));
      chk("mag_i", 64'(mag_i), 64'(exp_mi));
      chk("mag_q", 64'(mag_q), 64'(exp_mq));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("out_h", 64'(out_h), 64'(exp_oh));
      chk("err_orphan", 64'(err_orphan), 64'(exp_err));
    end
    if (reset) begin
      m_rr = 0;
      m_tags.delete();
      exp_mv  = 1'b0;
      exp_mi  = '0;
      exp_mq  = '0;
      exp_oh  = '0;
      exp_ov  = '0;
      exp_err = 1'b0;
      m_ok    = 1'b1;
    end else if (m_ok) begin
      exp_ov = '0;
      if (mag_h_valid) begin
        if (m_tags.size() > 0) begin
          t      = m_tags.pop_front();
          exp_ov = 4'(1 << t);
          exp_oh = mag_h;
          ret_log.push_back(t);
        end else begin
          exp_err = 1'b1;
        end
      end
      exp_mv = (g >= 0);
      if (g >= 0) begin
        exp_mi = s_i[16*g +: 16];
        exp_mq = s_q[16*g +: 16];
        m_tags.push_back(g);
        m_rr = (g + 1) % NCH;
        grant_log.push_back(g);
      end
    end
  end

  task automatic do_reset();
    s_valid = '0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    repeat (n) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int per_ch[4];
    int exp_seq[8];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    reset       = 1'b1;
    s_valid     = '0;
    s_i         = '0;
    s_q         = '0;
    mag_h       = '0;
    mag_h_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_mag_valid", 64'(mag_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_mag_i", 64'(mag_i), 64'd0);

    // Single sample on channel 2: 3/4 must come back as 5 on channel 2.
    unit_lat       = 3;
    s_i[47:32]     = 16'd3;
    s_q[47:32]     = 16'd4;
    s_valid        = 4'b0100;
    #1;
    chk("t1_ready", 64'(s_ready), 64'b0100);
    tick();
    s_valid = '0;
    #1;
    chk("t1_mag_valid", 64'(mag_valid), 64'd1);
    chk("t1_mag_i", 64'(mag_i), 64'd3);
    chk("t1_mag_q", 64'(mag_q), 64'd4);
    n = 0;
    while (mag_h_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t1_result_seen", 64'(n < 20), 64'd1);
    tick();
    chk("t1_out_h", 64'(out_h), 64'd5);
    chk("t1_out_valid", 64'(out_valid), 64'b0100);
    idle(5);

    // All four channels for 8 cycles: strict rotation from channel 0.
    do_reset();
    grant_log.delete();
    ret_log.delete();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        s_i[16*k +: 16] = 16'(k * 100 + c + 1);
        s_q[16*k +: 16] = 16'(c);
      end
      s_valid = 4'hf;
      tick();
    end
    idle(20);
    chk("t2_grant_count", 64'(grant_log.size()), 64'd8);
    chk("t2_ret_count", 64'(ret_log.size()), 64'd8);
    per_ch = '{0, 0, 0, 0};
    if (grant_log.size() == 8 && ret_log.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_grant_order", 64'(grant_log[i]), 64'(exp_seq[i]));
        chk("t2_ret_order", 64'(ret_log[i]), 64'(exp_seq[i]));
        per_ch[ret_log[i]]++;
      end
    end
    for (int k = 0; k < 4; k++) chk("t2_per_channel", 64'(per_ch[k]), 64'd2);

    // Unit slower than the FIFO depth: exactly DEPTH transfers, then stall.
    do_reset();
    unit_lat = 45;
    grant_log.delete();
    s_valid = 4'hf;
    repeat (38) tick();
    #1;
    chk("t3_transfers", 64'(grant_log.size()), 64'(DEPTH));
    chk("t3_ready_full", 64'(s_ready), 64'd0);
    repeat (20) tick();
    idle(90);

    // Steady inflight of DEPTH-1 with push and pop in the same cycle.
    do_reset();
    unit_lat = 30;
    grant_log.delete();
    s_valid = 4'hf;
    repeat (80) tick();
    chk("t4_no_stall", 64'(grant_log.size()), 64'd80);
    idle(45);

    // Result with nothing outstanding: sticky error, cleared by reset.
    do_reset();
    force_orphan = 1'b1;
    tick();
    force_orphan = 1'b0;
    tick();
    chk("t5_err_set", 64'(err_orphan), 64'd1);
    chk("t5_no_out", 64'(out_valid), 64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    chk("t5_err_cleared", 64'(err_orphan), 64'd0);

    // Reset with 5 samples in flight: late results become orphans.
    unit_lat = 20;
    grant_log.delete();
    s_valid = 4'b0001;
    repeat (5) tick();
    chk("t6_single_req", 64'(grant_log.size()), 64'd5);
    idle(1);
    do_reset();
    idle(25);
    chk("t6_err_after", 64'(err_orphan), 64'd1);
    chk("t6_unit_drained", 64'(uq.size()), 64'd0);
    s_valid = 4'hf;
    #1;
    chk("t6_rr_zero", 64'(s_ready), 64'b0001);
    tick();
    s_valid = 4'b1000;
    #1;
    chk("t6_ch3_grant", 64'(s_ready), 64'b1000);
    tick();
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/magnitude_arbiter.md
# magnitude_arbiter

Shares one I/Q magnitude unit (squares, sum, sqrt; fixed-latency pipeline with valid in/out and no backpressure) between NCH independent I/Q channels. Round-robin arbitration, one sample issued per cycle maximum. Each in-flight sample carries a channel tag so results return to the originating channel. Sits between the per-channel downconverter outputs and the envelope/detector stages.

## Interface
- NCH, 4, number of requesting channels (2..8)
- DEPTH, 32, max samples in flight in the magnitude unit; must be ≥ unit latency + 2 for full throughput (power of two)
- aclk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- s_i  in  NCH*16  signed I per channel, channel k at [16k+15:16k]
- s_q  in  NCH*16  signed Q per channel, same packing
- s_valid  in  NCH  per-channel sample valid
- s_ready  out  NCH  per-channel grant, at most one bit set
- mag_i  out  16  signed I to magnitude unit
- mag_q  out  16  signed Q to magnitude unit
- mag_valid  out  1  issue strobe to magnitude unit
- mag_h  in  16  magnitude result from unit
- mag_h_valid  in  1  result strobe from unit
- out_h  out  16  returned magnitude, common to all channels
- out_valid  out  NCH  one-hot: out_h belongs to channel k
- err_orphan  out  1  sticky: result arrived with no tag outstanding

## Operation
- Transfer on channel k when s_valid[k] & s_ready[k].
- s_ready is combinational from s_valid, rr_ptr, inflight: if inflight == DEPTH, all zero; else the first k with s_valid[k] set, searching rr_ptr, rr_ptr+1, … mod NCH.
- On transfer: register s_i/s_q of k onto mag_i/mag_q, mag_valid = 1 next cycle; push tag k into tag FIFO; rr_ptr ← (k+1) mod NCH. No transfer: mag_valid = 0, rr_ptr holds, mag_i/mag_q hold.
- On mag_h_valid with FIFO non-empty: pop tag t; next cycle out_h ← mag_h, out_valid ← one-hot(t). Otherwise out_valid = 0, out_h holds.
- On mag_h_valid with FIFO empty: result dropped, err_orphan ← 1, held until reset.
- inflight: +1 on transfer, −1 on valid pop; both in one cycle → unchanged. Equals FIFO occupancy; never exceeds DEPTH.
- Ordering: the magnitude unit is in-order, so FIFO pop order is the result order; no reordering logic.
- Reset: rr_ptr = 0, inflight = 0, FIFO empty, mag_valid = 0, mag_i = mag_q = 0, out_valid = 0, out_h = 0, err_orphan = 0. Samples in flight in the unit at reset return afterwards as orphans: dropped, err_orphan set. The system resets the magnitude unit on the same reset to avoid this.

## Timing
- Issue latency: transfer in cycle t → mag_valid in t+1.
- Return latency: mag_h_valid in cycle r → out_valid in r+1.
- End-to-end: 2 + unit latency cycles.
- Throughput: one sample/cycle aggregate. With all NCH valid, each channel is granted exactly once per NCH cycles.
- FIFO full (inflight == DEPTH) and result popped in the same cycle: no grant that cycle. Grant logic uses the registered count; one-cycle bubble accepted.
- Single requester: granted every cycle; rr_ptr still advances past it.

## Structure
- Package magnitude_arb_pkg: TAG_W = $clog2(NCH) (min 1), tag type, one-hot decode function, DEPTH default.
- Sub-module tag_fifo: synchronous FIFO, WIDTH=TAG_W, DEPTH, first-word-fall-through, push/pop/full/empty/count, synchronous active-high reset.
- Top: round-robin priority select, issue register, return register, inflight counter, err flag.

## Test plan
- Reset, then channel 2 only, s_i=3, s_q=4 for one cycle → s_ready=0100; next cycle mag_valid with 3/4. Unit model returns 5 → out_h=5, out_valid=0100 one cycle after mag_h_valid.
- All four channels valid for 8 cycles → grants 0,1,2,3,0,1,2,3; out_valid order identical; each channel sees 2 results.
- Unit model stalled returning (latency > DEPTH), continuous requests → exactly DEPTH transfers, then s_ready=0 until first result. Next grant one cycle after that pop.
- Push and pop in the same cycle at inflight=DEPTH−1 → inflight stays DEPTH−1; no lost or duplicated tag.
- mag_h_valid with nothing outstanding → no out_valid, err_orphan=1 and stays 1; reset clears it.
- Reset asserted with 5 samples in flight, unit not reset → the 5 late results are dropped; err_orphan=1; rr_ptr=0; next request on channel 3 is granted immediately.
